seq_array_ctrl: RTL and testbench



---
 rtl/seq_array_ctrl_pkg.sv | 49 ++++
 rtl/seq_array_ctrl_timer.sv | 30 +++
 rtl/seq_array_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_seq_array_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_array_ctrl_pkg.sv
// Shared types for the SequencerArray row controller: array geometry,
// the array opcode type and the constants the controller issues, and the
// command, status and controller state encodings.
package seq_array_ctrl_pkg;

    // Array geometry shared with the SequencerArray.
    localparam int TGT_BITS  = 16;
    localparam int ROW_BITS  = 64;
    localparam int GROUP_CNT = 8;

    // Array opcode type.
    localparam int OPCODE_BITS = 2;
    typedef logic [OPCODE_BITS-1:0] opcode_t;

    // Opcodes issued by the controller.
    localparam opcode_t OP_NOP   = opcode_t'(0);
    localparam opcode_t OP_SCAN  = opcode_t'(1);
    localparam opcode_t OP_WRITE = opcode_t'(2);

    typedef enum logic [1:0] {
        CMD_SCAN   = 2'd0,
        CMD_INSERT = 2'd1,
        CMD_READ   = 2'd2,
        CMD_RSVD   = 2'd3
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_ROW_FULL = 2'd1,
        ST_BAD_CMD  = 2'd2
    } rsp_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SCAN,
        S_WRITE,
        S_STORE,
        S_RESP
    } ctrl_state_e;

    // Largest of three latencies; sizes the shared wait counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_array_ctrl_timer.sv
// seq_lat_timer: loadable down-counter. o_done is high for exactly one
// cycle, i_value cycles after the cycle in which i_load was asserted.
module seq_lat_timer #(
    parameter int CNT_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [CNT_BITS-1:0] i_value,
    output logic                o_done
);

    logic [CNT_BITS-1:0] r_count;

    // Load the wait length, then count down to zero and park there.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values and simulation order cannot matter.
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_BITS'(1);
        end
    end

    assign o_done = (r_count == CNT_BITS'(1));

endmodule

// File: rtl/seq_array_ctrl.sv
// seq_array_ctrl: runs one command at a time through the SequencerArray:
// fetch a DRAM row, scan it against the target, and for inserts write the
// modified row back. Optional statistics counters are enabled by defining
// SEQ_CTRL_STATS_EN.
module seq_array_ctrl
    import seq_array_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DRAM_LAT  = 2,
    parameter int SCAN_LAT  = 3,
    parameter int WR_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic [1:0]             cmdKind,
    input  logic [ADDR_BITS-1:0]   cmdAddr,
    input  logic [TGT_BITS-1:0]    cmdTarget,
    output logic                   memRdEn,
    output logic                   memWrEn,
    output logic [ADDR_BITS-1:0]   memAddr,
    input  logic [ROW_BITS-1:0]    memRdData,
    output logic [ROW_BITS-1:0]    memWrData,
    output logic [OPCODE_BITS-1:0] seqOp,
    output logic [TGT_BITS-1:0]    seqTarget,
    output logic [ROW_BITS-1:0]    seqRow,
    input  logic [ROW_BITS-1:0]    arrRow,
    input  logic [GROUP_CNT-1:0]   arrMask,
    input  logic                   arrFull,
    output logic                   rspValid,
    output logic [GROUP_CNT-1:0]   rspMask,
    output logic [1:0]             rspStatus
`ifdef SEQ_CTRL_STATS_EN
    ,
    output logic [15:0]            statScans,
    output logic [15:0]            statInserts,
    output logic [15:0]            statFull
`endif
);

    localparam int MAX_LAT  = max3(DRAM_LAT, SCAN_LAT, WR_LAT);
    localparam int CNT_BITS = $clog2(MAX_LAT) + 1;

    generate
        if (DRAM_LAT < 1 || SCAN_LAT < 1 || WR_LAT < 1) begin : g_bad_lat
            $error("seq_array_ctrl: DRAM_LAT, SCAN_LAT and WR_LAT must all be >= 1");
        end
    endgenerate

    ctrl_state_e           r_state;
    ctrl_state_e           w_next;
    cmd_kind_e             r_kind;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [TGT_BITS-1:0]   r_target;
    logic [ROW_BITS-1:0]   r_row;
    logic [GROUP_CNT-1:0]  r_scan_mask;
    logic [GROUP_CNT-1:0]  r_rsp_mask;
    rsp_status_e           r_rsp_status;
    logic                  r_issue;

    logic                  w_accept;
    logic                  w_rd_issue;
    logic                  w_timer_load;
    logic [CNT_BITS-1:0]   w_timer_value;
    logic                  w_timer_done;
    logic                  w_rsp_load;
    logic [GROUP_CNT-1:0]  w_rsp_mask;
    rsp_status_e           w_rsp_status;

    assign w_accept   = (r_state == S_IDLE) && cmdValid;
    // Strobes are masked while reset is high so an aborted command never
    // reaches DRAM or the requester, even in the reset cycle itself.
    assign w_rd_issue = !reset && w_accept && (cmd_kind_e'(cmdKind) != CMD_RSVD);

    seq_lat_timer #(
        .CNT_BITS (CNT_BITS)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_timer_load),
        .i_value (w_timer_value),
        .o_done  (w_timer_done)
    );

    // Next-state, timer loads and the response to publish on entering RESP.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned and infers a latch.
        w_next        = r_state;
        w_timer_load  = 1'b0;
        w_timer_value = '0;
        w_rsp_load    = 1'b0;
        w_rsp_mask    = '0;
        w_rsp_status  = ST_OK;
        case (r_state)
            S_IDLE: begin
                if (cmdValid) begin
                    if (cmd_kind_e'(cmdKind) == CMD_RSVD) begin
                        w_next       = S_RESP;
                        w_rsp_load   = 1'b1;
                        w_rsp_status = ST_BAD_CMD;
                    end else begin
                        w_next        = S_FETCH;
                        w_timer_load  = 1'b1;
                        w_timer_value = CNT_BITS'(DRAM_LAT);
                    end
                end
            end
            S_FETCH: begin
                if (w_timer_done) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                // The wait starts in the cycle the opcode is issued.
                if (r_issue) begin
                    w_timer_load  = 1'b1;
                    w_timer_value = CNT_BITS'(SCAN_LAT);
                end else if (w_timer_done) begin
                    if (r_kind == CMD_INSERT && !arrFull) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next       = S_RESP;
                        w_rsp_load   = 1'b1;
                        w_rsp_mask   = arrMask;
                        w_rsp_status = (r_kind == CMD_INSERT) ? ST_ROW_FULL : ST_OK;
                    end
                end
            end
            S_WRITE: begin
                if (r_issue) begin
                    w_timer_load  = 1'b1;
                    w_timer_value = CNT_BITS'(WR_LAT);
                end else if (w_timer_done) begin
                    w_next = S_STORE;
                end
            end
            S_STORE: begin
                w_next       = S_RESP;
                w_rsp_load   = 1'b1;
                w_rsp_mask   = r_scan_mask;
                w_rsp_status = ST_OK;
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, command latch, row buffer, scan capture and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_kind       <= CMD_SCAN;
            r_addr       <= '0;
            r_target     <= '0;
            r_row        <= '0;
            r_scan_mask  <= '0;
            r_rsp_mask   <= '0;
            r_rsp_status <= ST_OK;
            r_issue      <= 1'b0;
        end else begin
            r_state <= w_next;
            // One-cycle flag marking the first cycle of SCAN or WRITE.
            r_issue <= (w_next != r_state) && (w_next == S_SCAN || w_next == S_WRITE);
            if (w_accept) begin
                r_kind   <= cmd_kind_e'(cmdKind);
                r_addr   <= cmdAddr;
                r_target <= cmdTarget;
            end
            if (r_state == S_FETCH && w_timer_done) begin
                r_row <= memRdData;
            end
            if (r_state == S_SCAN && !r_issue && w_timer_done) begin
                r_scan_mask <= arrMask;
            end
            if (r_state == S_WRITE && !r_issue && w_timer_done) begin
                r_row <= arrRow;
            end
            if (w_rsp_load) begin
                r_rsp_mask   <= w_rsp_mask;
                r_rsp_status <= w_rsp_status;
            end
        end
    end

    // Opcode to the array: one issue cycle per SCAN/WRITE visit, NOP otherwise.
    always_comb begin
        seqOp = OP_NOP;
        if (!reset && r_issue && r_state == S_SCAN) begin
            seqOp = OP_SCAN;
        end else if (!reset && r_issue && r_state == S_WRITE) begin
            seqOp = OP_WRITE;
        end
    end

    assign cmdReady  = (r_state == S_IDLE);
    assign memRdEn   = w_rd_issue;
    assign memWrEn   = !reset && (r_state == S_STORE);
    assign memAddr   = w_rd_issue ? cmdAddr : r_addr;
    assign memWrData = r_row;
    assign seqRow    = r_row;
    assign seqTarget = r_target;
    assign rspValid  = !reset && (r_state == S_RESP);
    assign rspMask   = r_rsp_mask;
    assign rspStatus = r_rsp_status;

`ifdef SEQ_CTRL_STATS_EN
    logic [15:0] r_stat_scans;
    logic [15:0] r_stat_inserts;
    logic [15:0] r_stat_full;

    // Tally each completed command by outcome; counters stick at 0xFFFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_scans   <= '0;
            r_stat_inserts <= '0;
            r_stat_full    <= '0;
        end else if (r_state == S_RESP) begin
            if (r_rsp_status == ST_ROW_FULL) begin
                if (r_stat_full != 16'hFFFF) r_stat_full <= r_stat_full + 16'd1;
            end else if (r_rsp_status == ST_OK) begin
                if (r_kind == CMD_INSERT) begin
                    if (r_stat_inserts != 16'hFFFF) r_stat_inserts <= r_stat_inserts + 16'd1;
                end else begin
                    if (r_stat_scans != 16'hFFFF) r_stat_scans <= r_stat_scans + 16'd1;
                end
            end
        end
    end

    assign statScans   = r_stat_scans;
    assign statInserts = r_stat_inserts;
    assign statFull    = r_stat_full;
`endif

endmodule

// File: tb/tb_seq_array_ctrl.sv
// Directed bench for seq_array_ctrl with small DRAM and array models.
// Cycle 0 is the cycle in which a command is presented; outputs are
// sampled on the falling edge.
module tb_seq_array_ctrl;
    import seq_array_ctrl_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   cmdValid;
    logic                   cmdReady;
    logic [1:0]             cmdKind;
    logic [9:0]             cmdAddr;
    logic [TGT_BITS-1:0]    cmdTarget;
    logic                   memRdEn;
    logic                   memWrEn;
    logic [9:0]             memAddr;
    logic [ROW_BITS-1:0]    memRdData;
    logic [ROW_BITS-1:0]    memWrData;
    logic [OPCODE_BITS-1:0] seqOp;
    logic [TGT_BITS-1:0]    seqTarget;
    logic [ROW_BITS-1:0]    seqRow;
    logic [ROW_BITS-1:0]    arrRow;
    logic [GROUP_CNT-1:0]   arrMask;
    logic                   arrFull;
    logic                   rspValid;
    logic [GROUP_CNT-1:0]   rspMask;
    logic [1:0]             rspStatus;
`ifdef SEQ_CTRL_STATS_EN
    logic [15:0]            statScans;
    logic [15:0]            statInserts;
    logic [15:0]            statFull;
`endif

    seq_array_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdKind   (cmdKind),
        .cmdAddr   (cmdAddr),
        .cmdTarget (cmdTarget),
        .memRdEn   (memRdEn),
        .memWrEn   (memWrEn),
        .memAddr   (memAddr),
        .memRdData (memRdData),
        .memWrData (memWrData),
        .seqOp     (seqOp),
        .seqTarget (seqTarget),
        .seqRow    (seqRow),
        .arrRow    (arrRow),
        .arrMask   (arrMask),
        .arrFull   (arrFull),
        .rspValid  (rspValid),
        .rspMask   (rspMask),
        .rspStatus (rspStatus)
`ifdef SEQ_CTRL_STATS_EN
        ,
        .statScans   (statScans),
        .statInserts (statInserts),
        .statFull    (statFull)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [63:0] ROW5    = 64'h11111111_34111111;  // 0x34 in group 3
    localparam logic [63:0] ROW7    = 64'h34341111_11111134;  // 0x34 in groups 0,6,7
    localparam logic [63:0] ROW_A5  = 64'hA5A5A5A5_A5A5A5A5;

    function automatic logic [63:0] dram_row(input logic [9:0] a);
        case (a)
            10'd5:   return ROW5;
            10'd7:   return ROW7;
            default: return 64'h0101010101010101;
        endcase
    endfunction

    // DRAM model: data valid only exactly two cycles after the read strobe.
    logic       rd_v1, rd_v2;
    logic [9:0] rd_a1, rd_a2;
    always @(posedge clk) begin
        rd_v1 <= memRdEn;
        rd_a1 <= memAddr;
        rd_v2 <= rd_v1;
        rd_a2 <= rd_a1;
    end
    assign memRdData = rd_v2 ? dram_row(rd_a2) : 64'hDEADBEEF_DEADBEEF;

    // Array model: mask/full valid three cycles after the scan opcode,
    // modified row valid one cycle after the write opcode.
    logic                tb_full;
    logic [2:0]          sc_v;
    logic [ROW_BITS-1:0] sc_row;
    logic [TGT_BITS-1:0] sc_tgt;
    logic                wr_v;
    always @(posedge clk) begin
        sc_v <= {sc_v[1:0], (seqOp == OP_SCAN)};
        if (seqOp == OP_SCAN) begin
            sc_row <= seqRow;
            sc_tgt <= seqTarget;
        end
        wr_v <= (seqOp == OP_WRITE);
    end

    function automatic logic [7:0] model_mask(input logic [63:0] row, input logic [15:0] tgt);
        logic [7:0] m;
        for (int g = 0; g < 8; g++) m[g] = (row[g*8 +: 8] == tgt[7:0]);
        return m;
    endfunction

    assign arrMask = sc_v[2] ? model_mask(sc_row, sc_tgt) : 8'h5A;
    assign arrFull = sc_v[2] ? tb_full : ~tb_full;
    assign arrRow  = wr_v ? ROW_A5 : 64'h0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-run observation record.
    int          n_rd, rd_cyc, n_scan, scan_cyc, n_wop, wop_cyc, n_wr, wr_cyc, n_rsp, rsp_cyc, n_acc;
    int          acc_cyc [0:3];
    logic [9:0]  rd_addr, wr_addr;
    logic [63:0] wr_data, scan_row, wop_row;
    logic [15:0] scan_tgt;
    logic [7:0]  rsp_mask;
    logic [1:0]  rsp_status;
    logic        ready_hist [0:31];

    // Run ncyc cycles from cycle 0; cmdValid drops after last_valid, reset is
    // high during rst_cyc (-1 for none).
    task automatic run(input int ncyc, input int last_valid, input int rst_cyc);
        n_rd = 0; n_scan = 0; n_wop = 0; n_wr = 0; n_rsp = 0; n_acc = 0;
        rd_cyc = -1; scan_cyc = -1; wop_cyc = -1; wr_cyc = -1; rsp_cyc = -1;
        for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
        for (int i = 0; i < 32; i++) ready_hist[i] = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            reset = (c == rst_cyc);
            if (c > last_valid) cmdValid = 1'b0;
            @(negedge clk);
            ready_hist[c] = cmdReady;
            if (cmdValid && cmdReady && n_acc < 4) begin acc_cyc[n_acc] = c; n_acc++; end
            if (memRdEn) begin n_rd++; rd_cyc = c; rd_addr = memAddr; end
            if (seqOp == OP_SCAN) begin n_scan++; scan_cyc = c; scan_row = seqRow; scan_tgt = seqTarget; end
            if (seqOp == OP_WRITE) begin n_wop++; wop_cyc = c; wop_row = seqRow; end
            if (memWrEn) begin n_wr++; wr_cyc = c; wr_addr = memAddr; wr_data = memWrData; end
            if (rspValid) begin n_rsp++; rsp_cyc = c; rsp_mask = rspMask; rsp_status = rspStatus; end
            @(posedge clk); #1;
        end
        cmdValid = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic start(input logic [1:0] kind, input logic [9:0] addr,
                         input logic [15:0] tgt, input logic full);
        @(posedge clk); #1;
        cmdKind   = kind;
        cmdAddr   = addr;
        cmdTarget = tgt;
        tb_full   = full;
        cmdValid  = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmdValid = 1'b0; cmdKind = '0; cmdAddr = '0; cmdTarget = '0; tb_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_ready",   cmdReady,  1);
        check("rst_rden",    memRdEn,   0);
        check("rst_wren",    memWrEn,   0);
        check("rst_rspv",    rspValid,  0);
        check("rst_seqop",   seqOp,     OP_NOP);
        check("rst_mask",    rspMask,   0);
        check("rst_status",  rspStatus, 0);
        check("rst_seqrow",  seqRow,    0);
        check("rst_seqtgt",  seqTarget, 0);
        check("rst_memaddr", memAddr,   0);
        check("rst_wrdata",  memWrData, 0);

        // SCAN addr 5, target 0x1234: match in group 3.
        start(2'd0, 10'd5, 16'h1234, 1'b0);
        run(12, 0, -1);
        check("scan_acc_n",   n_acc,      1);
        check("scan_rd_n",    n_rd,       1);
        check("scan_rd_cyc",  rd_cyc,     0);
        check("scan_rd_addr", rd_addr,    5);
        check("scan_op_n",    n_scan,     1);
        check("scan_op_cyc",  scan_cyc,   3);
        check("scan_row",     scan_row,   ROW5);
        check("scan_tgt",     scan_tgt,   16'h1234);
        check("scan_wop_n",   n_wop,      0);
        check("scan_wr_n",    n_wr,       0);
        check("scan_rsp_n",   n_rsp,      1);
        check("scan_rsp_cyc", rsp_cyc,    7);
        check("scan_mask",    rsp_mask,   8'h08);
        check("scan_status",  rsp_status, 0);
        check("scan_ready8",  ready_hist[8], 1);
        check("scan_hold",    rspMask,    8'h08);

        // INSERT addr 7, not full: write-back of the 0xA5 row.
        start(2'd1, 10'd7, 16'h5634, 1'b0);
        run(13, 0, -1);
        check("ins_rd_cyc",  rd_cyc,     0);
        check("ins_op_cyc",  scan_cyc,   3);
        check("ins_wop_cyc", wop_cyc,    7);
        check("ins_wop_row", wop_row,    ROW7);
        check("ins_wr_n",    n_wr,       1);
        check("ins_wr_cyc",  wr_cyc,     9);
        check("ins_wr_addr", wr_addr,    7);
        check("ins_wr_data", wr_data,    ROW_A5);
        check("ins_rsp_cyc", rsp_cyc,    10);
        check("ins_mask",    rsp_mask,   8'hC1);
        check("ins_status",  rsp_status, 0);
        check("ins_ready11", ready_hist[11], 1);
        check("ins_busy10",  ready_hist[10], 0);

        // INSERT addr 7, row full: refused, no write.
        start(2'd1, 10'd7, 16'h5634, 1'b1);
        run(12, 0, -1);
        check("full_rsp_cyc", rsp_cyc,    7);
        check("full_status",  rsp_status, 1);
        check("full_mask",    rsp_mask,   8'hC1);
        check("full_wop_n",   n_wop,      0);
        check("full_wr_n",    n_wr,       0);

        // READ addr 5: response mask is the scan result.
        start(2'd2, 10'd5, 16'h0034, 1'b0);
        run(12, 0, -1);
        check("read_rsp_cyc", rsp_cyc,    7);
        check("read_mask",    rsp_mask,   8'h08);
        check("read_status",  rsp_status, 0);
        check("read_wr_n",    n_wr,       0);

        // Reserved kind: BAD_CMD at cycle 1, no memory traffic.
        start(2'd3, 10'd9, 16'h0001, 1'b0);
        run(6, 0, -1);
        check("bad_rsp_cyc", rsp_cyc,    1);
        check("bad_status",  rsp_status, 2);
        check("bad_rd_n",    n_rd,       0);
        check("bad_wr_n",    n_wr,       0);
        check("bad_ready2",  ready_hist[2], 1);

        // Reset during the write-back of an INSERT: everything dropped.
        start(2'd1, 10'd7, 16'h5634, 1'b0);
        run(14, 0, 9);
        check("rstw_wop_n",   n_wop, 1);
        check("rstw_wr_n",    n_wr,  0);
        check("rstw_rsp_n",   n_rsp, 0);
        check("rstw_ready10", ready_hist[10], 1);
        check("rstw_mask",    rspMask, 0);

        // cmdValid held for three SCANs: accepts at 0, 8, 16 only.
        start(2'd0, 10'd5, 16'h1234, 1'b0);
        run(24, 16, -1);
        check("b2b_acc_n", n_acc,      3);
        check("b2b_acc0",  acc_cyc[0], 0);
        check("b2b_acc1",  acc_cyc[1], 8);
        check("b2b_acc2",  acc_cyc[2], 16);
        check("b2b_rsp_n", n_rsp,      3);
        begin
            int n_ready = 0;
            for (int c = 0; c < 24; c++) if (ready_hist[c]) n_ready++;
            check("b2b_ready_n", n_ready, 3);
        end
`ifdef SEQ_CTRL_STATS_EN
        @(negedge clk);
        check("stat_scans",   statScans,   3);
        check("stat_inserts", statInserts, 0);
        check("stat_full",    statFull,    0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
